// File: rtl/mux_n_skid.sv
// mux_n_skid
//   N-way operand select feeding a registered two-entry valid/ready skid stage.
//   One entry is accepted per cycle (chosen by sel) and presented the cycle after.
//   Both in_ready and out_valid come straight from registers, so there is no
//   combinational path from out_ready back to in_ready.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
//   high. An accept is in_valid && in_ready && !flush. A pop is
//   out_valid && out_ready. A held head (out_valid && !out_ready) keeps
//   out_data/out_err stable.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_data    N packed inputs, input k at [k*WIDTH +: WIDTH]
//   sel        input select, sampled on accept
//   in_valid   producer offers an entry
//   in_ready   block can accept (registered)
//   flush      drop every held entry and any same-cycle offer
//   out_data   head entry data
//   out_err    head entry was captured with sel >= N
//   out_valid  head entry valid
//   out_ready  consumer takes the head entry
//   dbg_state  current FSM state (0 EMPTY, 1 ONE, 2 TWO)
module mux_n_skid #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_main_data;
  logic               r_main_err;
  logic [WIDTH-1:0]   r_skid_data;
  logic               r_skid_err;

  logic [31:0]        w_sel_ext;
  logic               w_sel_err;
  logic [WIDTH-1:0]   w_mux_data;
  logic               w_accept;
  logic               w_pop;

  assign w_sel_ext = 32'(sel);
  // Only reachable for non-power-of-2 N; the entry then carries zero data.
  assign w_sel_err = (w_sel_ext >= 32'(N));

  always_comb begin
    w_mux_data = '0;
    for (int k = 0; k < N; k++) begin
      if (w_sel_ext == 32'(k)) begin
        w_mux_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_accept = in_valid && r_in_ready && !flush;
  assign w_pop    = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main_data <= '0;
      r_main_err  <= 1'b0;
      r_skid_data <= '0;
      r_skid_err  <= 1'b0;
    end else if (flush) begin
      // Data registers keep stale contents; only the control state clears.
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main_data <= w_mux_data;
            r_main_err  <= w_sel_err;
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            // Replace the head in place: no bubble.
            r_main_data <= w_mux_data;
            r_main_err  <= w_sel_err;
          end else if (w_accept) begin
            r_skid_data <= w_mux_data;
            r_skid_err  <= w_sel_err;
            r_state     <= ST_TWO;
            r_in_ready  <= 1'b0;
          end else if (w_pop) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            r_main_data <= r_skid_data;
            r_main_err  <= r_skid_err;
            r_state     <= ST_ONE;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main_data;
  assign out_err   = r_main_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mux_n_skid.sv
module tb_mux_n_skid;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT with N=4 ----------------
  logic [127:0] in_data4;
  logic [1:0]   sel4 = '0;
  logic         in_valid4 = 1'b0;
  logic         in_ready4;
  logic         flush4 = 1'b0;
  logic [31:0]  out_data4;
  logic         out_err4;
  logic         out_valid4;
  logic         out_ready4 = 1'b0;
  logic [1:0]   dbg_state4;

  mux_n_skid #(.WIDTH(32), .N(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data4),
    .sel       (sel4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .flush     (flush4),
    .out_data  (out_data4),
    .out_err   (out_err4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .dbg_state (dbg_state4)
  );

  // ---------------- DUT with N=3 ----------------
  logic [95:0]  in_data3;
  logic [1:0]   sel3 = '0;
  logic         in_valid3 = 1'b0;
  logic         in_ready3;
  logic         flush3 = 1'b0;
  logic [31:0]  out_data3;
  logic         out_err3;
  logic         out_valid3;
  logic         out_ready3 = 1'b0;
  logic [1:0]   dbg_state3;

  mux_n_skid #(.WIDTH(32), .N(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data3),
    .sel       (sel3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .flush     (flush3),
    .out_data  (out_data3),
    .out_err   (out_err3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .dbg_state (dbg_state3)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];   // {err, data}

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- vector table for dut4 ----------------
  // Each row: outputs expected during the cycle, and inputs driven for the next edge.
  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic        rdy;
    logic        fl;
    logic        ov;
    logic        ir;
    logic [31:0] d;
  } row_t;

  localparam int NROWS = 23;
  row_t tbl[NROWS];

  initial begin
    in_data4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    in_data3 = {32'hCCCC2222, 32'hBBBB1111, 32'hAAAA0000};

    // streaming
    tbl[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[1]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11111111};
    tbl[2]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22222222};
    tbl[3]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h33333333};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h44444444};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    // stall fill: A=sel2, B=sel0, C=sel3
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33333333};
    tbl[8]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h33333333};
    tbl[9]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h33333333};
    tbl[10] = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 32'h33333333};
    tbl[11] = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11111111};
    tbl[12] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h44444444};
    tbl[13] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    // flush in TWO with a simultaneous offer
    tbl[14] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[15] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22222222};
    tbl[16] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 32'h22222222};
    // flush while EMPTY drops the offered entry
    tbl[17] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
    tbl[18] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[19] = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    // flush in ONE under stall
    tbl[20] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22222222};
    tbl[21] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h22222222};
    tbl[22] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [32:0] head;
    logic [32:0] ent;
    logic [31:0] word;
    logic        v, rdy, fl;
    logic [1:0]  s;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ov4",  {63'd0, out_valid4}, 64'd0);
    check("rst_ir4",  {63'd0, in_ready4},  64'd1);
    check("rst_d4",   {32'd0, out_data4},  64'd0);
    check("rst_err4", {63'd0, out_err4},   64'd0);
    check("rst_ov3",  {63'd0, out_valid3}, 64'd0);
    check("rst_ir3",  {63'd0, in_ready3},  64'd1);
    reset = 1'b0;

    // table-driven vectors
    for (int i = 0; i < NROWS; i++) begin
      @(negedge clk);
      check($sformatf("row%0d_ov", i), {63'd0, out_valid4}, {63'd0, tbl[i].ov});
      check($sformatf("row%0d_ir", i), {63'd0, in_ready4},  {63'd0, tbl[i].ir});
      if (tbl[i].ov) begin
        check($sformatf("row%0d_d", i),   {32'd0, out_data4}, {32'd0, tbl[i].d});
        check($sformatf("row%0d_err", i), {63'd0, out_err4},  64'd0);
      end
      in_valid4  = tbl[i].v;
      sel4       = tbl[i].sel;
      out_ready4 = tbl[i].rdy;
      flush4     = tbl[i].fl;
    end

    // mid-operation reset while in TWO
    @(negedge clk);
    in_valid4 = 1'b1; sel4 = 2'd0; out_ready4 = 1'b0;
    @(negedge clk);
    sel4 = 2'd1;
    @(negedge clk);
    check("two_ir", {63'd0, in_ready4}, 64'd0);
    reset = 1'b1; sel4 = 2'd2; out_ready4 = 1'b1;
    @(negedge clk);
    check("mrst_ov",  {63'd0, out_valid4}, 64'd0);
    check("mrst_ir",  {63'd0, in_ready4},  64'd1);
    check("mrst_d",   {32'd0, out_data4},  64'd0);
    check("mrst_err", {63'd0, out_err4},   64'd0);
    reset = 1'b0; sel4 = 2'd3;
    @(negedge clk);
    check("post_ov", {63'd0, out_valid4}, 64'd1);
    check("post_d",  {32'd0, out_data4},  {32'd0, 32'h44444444});
    in_valid4 = 1'b0;
    @(negedge clk);
    check("post_empty", {63'd0, out_valid4}, 64'd0);

    // out-of-range select on N=3
    in_valid3 = 1'b1; sel3 = 2'd3; out_ready3 = 1'b1;
    @(negedge clk);
    check("oor_ov",  {63'd0, out_valid3}, 64'd1);
    check("oor_d",   {32'd0, out_data3},  64'd0);
    check("oor_err", {63'd0, out_err3},   64'd1);
    sel3 = 2'd1;
    @(negedge clk);
    check("in1_d",   {32'd0, out_data3},  {32'd0, 32'hBBBB1111});
    check("in1_err", {63'd0, out_err3},   64'd0);
    in_valid3 = 1'b0;
    @(negedge clk);
    check("oor_empty", {63'd0, out_valid3}, 64'd0);

    // random regression on N=3 against a reference queue
    for (int c = 0; c < 500; c++) begin
      check("rnd_ov", {63'd0, out_valid3}, {63'd0, (exp_q.size() != 0)});
      check("rnd_ir", {63'd0, in_ready3},  {63'd0, (exp_q.size() < 2)});
      if (out_valid3 && exp_q.size() != 0) begin
        head = exp_q[0];
        check("rnd_head", {31'd0, out_err3, out_data3}, {31'd0, head});
      end
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 99) < 2);
      s   = 2'($urandom_range(0, 3));
      in_data3   = {$urandom, $urandom, $urandom};
      in_valid3  = v;
      out_ready3 = rdy;
      flush3     = fl;
      sel3       = s;
      if (fl) begin
        exp_q.delete();
      end else begin
        ent = 33'd0;
        if (s < 2'd3) begin
          word = in_data3[s*32 +: 32];
          ent  = {1'b0, word};
        end else begin
          ent  = {1'b1, 32'd0};
        end
        if (v && exp_q.size() < 2 && exp_q.size() != 0 && rdy) begin
          void'(exp_q.pop_front());
          exp_q.push_back(ent);
        end else if (v && exp_q.size() < 2) begin
          exp_q.push_back(ent);
        end else if (exp_q.size() != 0 && rdy) begin
          void'(exp_q.pop_front());
        end
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_n_skid.md
# mux_n_skid

Parametrised N-way operand select with a registered, two-entry valid/ready skid stage, for pipeline boundaries where a plain 2:1 mux no longer covers the cases. The block gains three things over a 2:1 mux: a generic width and input count, backpressure without a combinational ready path, and flush. It sits between a stage's operand-source selection (register file, ALU forward, memory forward, immediate) and the consuming stage. One entry is accepted per cycle, selected by `sel`, and presented one cycle later; the consumer can stall it without losing data.

## Interface
- `WIDTH`, default 32: data width of each input and of the output.
- `N`, default 4: number of selectable inputs; legal range is 2 or more.
- `SELW`, default `$clog2(N)`: select width.

- `clk` in, 1: rising-edge clock.
- `reset` in, 1: synchronous, active-high reset.
- `in_data` in, N*WIDTH: packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- `sel` in, SELW: selects the input, sampled only on accept.
- `in_valid` in, 1: producer offers an entry.
- `in_ready` out, 1: block can accept; driven from a register with no combinational path from `out_ready`.
- `flush` in, 1: discard all held entries.
- `out_data` out, WIDTH: data of the head entry.
- `out_err` out, 1: head entry was captured with `sel` >= N.
- `out_valid` out, 1: head entry is valid.
- `out_ready` in, 1: consumer takes the head entry.

## Operation
- An **accept** occurs when `in_valid && in_ready && !flush`.
- A **pop** occurs when `out_valid && out_ready`.
- On accept, the captured data is `in_data[sel*WIDTH +: WIDTH]` when `sel` < N.
  - When `sel` >= N (possible only for non-power-of-2 N), the captured data is all zeros and the entry's err bit is 1.
  - Otherwise the entry's err bit is 0.
- Storage is a main register (head) plus a skid register, each holding data and err. The FSM is below.
  - **EMPTY**: `out_valid`=0, `in_ready`=1.
    - Accept → ONE, with main loaded from the input.
  - **ONE**: `out_valid`=1, `in_ready`=1.
    - Accept and pop → ONE, main loaded with the new entry.
    - Accept without pop → TWO, skid loaded with the new entry.
    - Pop without accept → EMPTY.
    - Neither → hold.
  - **TWO**: `out_valid`=1, `in_ready`=0.
    - Pop → ONE, main loaded from skid.
    - No pop → hold.
- `in_ready` = (state != TWO) and is registered with the state.
- **Flush** has priority over everything. The next state is EMPTY and any same-cycle accept or pop is ignored (the input is dropped). Data registers may keep stale values.
- Ordering is strict FIFO: entries leave in acceptance order.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_err` must not change.
- `out_data` and `out_err` are don't-care while `out_valid`=0. The bench checks them only when valid.

## Timing
- **Reset (synchronous)**: state is EMPTY; `out_valid`=0, `in_ready`=1, `out_data`=0, `out_err`=0.
  - Reset asserted mid-operation drops both entries at the next edge.
  - Reset overrides `flush` and `in_valid`.
- **Latency**: an entry accepted at edge t is visible with `out_valid`=1 after edge t.
- **Throughput**: one entry per cycle in steady state when `out_ready`=1.
- **Backpressure**: at most two entries are held. `in_ready` falls the cycle after the second entry is accepted without a pop, and rises the cycle after a pop from TWO.
- **Empty**: a pop from EMPTY cannot occur, since `out_valid`=0. `out_ready` is ignored there.
- **Simultaneous events in ONE**: accept and pop in the same cycle stays in ONE with no bubble.
- **Flush timing**: after a flush at edge t, `out_valid`=0 and `in_ready`=1 after edge t. The next accept is possible in the following cycle.
- **Critical path**: the select mux feeds a register. No path runs from `out_ready` to `in_ready` or to `in_data`.

## Test plan
- **Streaming**: WIDTH=32, N=4; inputs are 0x11111111, 0x22222222, 0x33333333, 0x44444444. Drive `sel` = 0,1,2,3 on four consecutive cycles with `in_valid`=1 and `out_ready`=1 → `out_data` shows 0x11111111 through 0x44444444 on the four cycles after each accept, `out_valid` stays 1 with no gaps, and `in_ready` stays 1.
- **Stall fill**: `out_ready`=0 with three offered entries A, B, C → A and B are accepted, `in_ready`=0 from the cycle after B, C is held off, and `out_data`=A stays stable. Raising `out_ready` pops A, then B, then C in order, and `in_ready` returns to 1 the cycle after the first pop.
- **Out-of-range select**: N=3 with `sel`=3 accepted → `out_data`=0 and `out_err`=1. The next entry with `sel`=1 shows input 1 and `out_err`=0.
- **Flush in TWO with simultaneous offer**: assert `flush` while in TWO with `in_valid`=1 → next cycle `out_valid`=0 and `in_ready`=1, and the offered entry never appears at the output.
- **Mid-operation reset**: assert `reset` in TWO with `in_valid`=1 and `out_ready`=1 → after the edge `out_valid`=0, `in_ready`=1, `out_data`=0 and `out_err`=0. An entry accepted after deassertion appears normally.
- **Random regression**: random `in_valid`, `out_ready` and `sel`, with flush about 2% of cycles, against a reference queue model → no loss, duplication or reordering, and output stability holds under stall.
